// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the two-requester memory port arbiter:
//   - default parameter values (word width, address width, read latency,
//     maximum hold time)
//   - requester-index type used for the "last granted" record and read tags
//   - arbiter state encoding
//   - small helper to pick the opposite requester
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_READ_LAT = 2;
    localparam int DEF_MAX_HOLD = 32;

    // Index of a requester (0 or 1)
    typedef logic [0:0] req_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    // The requester that is not idx; used to break ties away from the last owner
    function automatic req_idx_t other_idx(input req_idx_t idx);
        return ~idx;
    endfunction

endpackage

// File: rtl/mem_arb_rtag_pipe.sv
// ---------------------------------------------------------------------------
// mem_arb_rtag_pipe
// Read-return tag pipeline. Every accepted read enters a DEPTH-deep shift
// register carrying a valid bit and the issuing requester index; it emerges
// exactly DEPTH cycles later, aligned with the memory's read data.
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   asynchronous active-high reset, empties the pipeline
//   issue_valid in   a read is being issued this cycle
//   issue_tag   in   requester that issued the read
//   ret_valid   out  a read returns this cycle (registered)
//   ret_tag     out  requester the returning read belongs to (registered)
// ---------------------------------------------------------------------------
module mem_arb_rtag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEF_READ_LAT
) (
    input  logic     Clock,
    input  logic     Reset,
    input  logic     issue_valid,
    input  req_idx_t issue_tag,
    output logic     ret_valid,
    output req_idx_t ret_tag
);

    logic [DEPTH-1:0] vld_r;
    req_idx_t         tag_r [DEPTH];

    // Shift valid and tag one stage per cycle; reset drops reads in flight
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            vld_r <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                tag_r[i] <= 1'b0;
            end
        end else begin
            vld_r[0] <= issue_valid;
            tag_r[0] <= issue_tag;
            for (int i = 1; i < DEPTH; i++) begin
                vld_r[i] <= vld_r[i-1];
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign ret_valid = vld_r[DEPTH-1];
    assign ret_tag   = tag_r[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Grants a single-ported memory to one of two requesters at a time.
// IDLE picks a winner (ties go away from the last owner), OWNx forwards the
// owner's command to the memory, and DRAIN waits READ_LAT cycles so that
// reads issued by the old owner return before anyone else is granted.
// An owner is forced off after MAX_HOLD cycles if the other side is waiting.
// Ports:
//   Clock, Reset          clock and asynchronous active-high reset
//   Req0/Req1             requester wants ownership
//   Addr0/Addr1           requester address
//   RdEn0/RdEn1           requester read command
//   WrEn0/WrEn1           requester write command
//   WData0/WData1         requester write data
//   Gnt0/Gnt1             requester owns the port (registered)
//   RValid0/RValid1       read data on RData belongs to this requester
//   RData                 memory read data passed through
//   MemAddr/MemRE/MemWE/MemWData  command to the memory
//   MemRData              read data from the memory
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int READ_LAT = DEF_READ_LAT,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Addr0,
    input  logic [ADDR_W-1:0] Addr1,
    input  logic              RdEn0,
    input  logic              RdEn1,
    input  logic              WrEn0,
    input  logic              WrEn1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RValid0,
    output logic              RValid1,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemRE,
    output logic              MemWE,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int HOLD_W  = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam int DRAIN_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(READ_LAT - 1);

    arb_state_t         state_r;
    arb_state_t         state_next_s;
    req_idx_t           last_r;
    req_idx_t           last_next_s;
    logic [HOLD_W-1:0]  hold_cnt_r;
    logic [HOLD_W-1:0]  hold_cnt_next_s;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DRAIN_W-1:0] drain_cnt_next_s;
    logic               gnt0_r;
    logic               gnt1_r;
    req_idx_t           tie_winner_s;

    logic [ADDR_W-1:0]  mem_addr_s;
    logic [DATA_W-1:0]  mem_wdata_s;
    logic               mem_re_s;
    logic               mem_we_s;
    req_idx_t           issue_tag_s;
    logic               ret_valid_s;
    req_idx_t           ret_tag_s;

    assign tie_winner_s = other_idx(last_r);

    // Next-state, last-owner and counter update
    always_comb begin
        state_next_s     = state_r;
        last_next_s      = last_r;
        hold_cnt_next_s  = hold_cnt_r;
        drain_cnt_next_s = drain_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if ((Req0 && Req1 && (tie_winner_s == 1'b0)) || (Req0 && !Req1)) begin
                    state_next_s    = ST_OWN0;
                    last_next_s     = 1'b0;
                    hold_cnt_next_s = {HOLD_W{1'b0}};
                end else if (Req1) begin
                    state_next_s    = ST_OWN1;
                    last_next_s     = 1'b1;
                    hold_cnt_next_s = {HOLD_W{1'b0}};
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OWN0: begin
                if (!Req0 || (Req1 && (hold_cnt_r == HOLD_LAST))) begin
                    state_next_s     = ST_DRAIN;
                    drain_cnt_next_s = DRAIN_LOAD;
                end else if (hold_cnt_r != HOLD_LAST) begin
                    hold_cnt_next_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                end else begin
                    // Saturated while the other side is not asking
                    hold_cnt_next_s = hold_cnt_r;
                end
            end
            ST_OWN1: begin
                if (!Req1 || (Req0 && (hold_cnt_r == HOLD_LAST))) begin
                    state_next_s     = ST_DRAIN;
                    drain_cnt_next_s = DRAIN_LOAD;
                end else if (hold_cnt_r != HOLD_LAST) begin
                    hold_cnt_next_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
                end else begin
                    hold_cnt_next_s = hold_cnt_r;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r == {DRAIN_W{1'b0}}) begin
                    state_next_s = ST_IDLE;
                end else begin
                    drain_cnt_next_s = drain_cnt_r - {{(DRAIN_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_next_s     = ST_IDLE;
                drain_cnt_next_s = {DRAIN_W{1'b0}};
            end
        endcase
    end

    // State, counters and registered grants
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_r     <= ST_IDLE;
            last_r      <= 1'b1;
            hold_cnt_r  <= {HOLD_W{1'b0}};
            drain_cnt_r <= {DRAIN_W{1'b0}};
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            last_r      <= last_next_s;
            hold_cnt_r  <= hold_cnt_next_s;
            drain_cnt_r <= drain_cnt_next_s;
            gnt0_r      <= (state_next_s == ST_OWN0);
            gnt1_r      <= (state_next_s == ST_OWN1);
        end
    end

    // Forward the owner's command; write wins over a simultaneous read
    always_comb begin
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        mem_re_s    = 1'b0;
        mem_we_s    = 1'b0;
        issue_tag_s = 1'b0;
        case (state_r)
            ST_OWN0: begin
                mem_addr_s  = Addr0;
                mem_wdata_s = WData0;
                mem_we_s    = WrEn0;
                mem_re_s    = RdEn0 & ~WrEn0;
                issue_tag_s = 1'b0;
            end
            ST_OWN1: begin
                mem_addr_s  = Addr1;
                mem_wdata_s = WData1;
                mem_we_s    = WrEn1;
                mem_re_s    = RdEn1 & ~WrEn1;
                issue_tag_s = 1'b1;
            end
            default: begin
                mem_re_s = 1'b0;
                mem_we_s = 1'b0;
            end
        endcase
    end

    mem_arb_rtag_pipe #(
        .DEPTH (READ_LAT)
    ) u_rtag_pipe (
        .Clock       (Clock),
        .Reset       (Reset),
        .issue_valid (mem_re_s),
        .issue_tag   (issue_tag_s),
        .ret_valid   (ret_valid_s),
        .ret_tag     (ret_tag_s)
    );

    assign Gnt0     = gnt0_r;
    assign Gnt1     = gnt1_r;
    assign MemAddr  = mem_addr_s;
    assign MemWData = mem_wdata_s;
    assign MemRE    = mem_re_s;
    assign MemWE    = mem_we_s;
    assign RValid0  = ret_valid_s & (ret_tag_s == 1'b0);
    assign RValid1  = ret_valid_s & (ret_tag_s == 1'b1);
    // Read data is forced to zero while reset is held so every output is quiet
    assign RData    = Reset ? {DATA_W{1'b0}} : MemRData;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus with a read-return scoreboard: each issued read pushes
// {owner, data, return cycle}; a monitor pops on every RValid and compares.
// A small 2-cycle memory model returns data = {3'b011, addr}.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic       Clock;
    logic       Reset;
    logic       Req0, Req1;
    logic [4:0] Addr0, Addr1;
    logic       RdEn0, RdEn1, WrEn0, WrEn1;
    logic [7:0] WData0, WData1;
    logic       Gnt0, Gnt1, RValid0, RValid1;
    logic [7:0] RData;
    logic [4:0] MemAddr;
    logic       MemRE, MemWE;
    logic [7:0] MemWData;
    logic [7:0] MemRData;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit         tag;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    mem_port_arbiter dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Req0     (Req0),
        .Req1     (Req1),
        .Addr0    (Addr0),
        .Addr1    (Addr1),
        .RdEn0    (RdEn0),
        .RdEn1    (RdEn1),
        .WrEn0    (WrEn0),
        .WrEn1    (WrEn1),
        .WData0   (WData0),
        .WData1   (WData1),
        .Gnt0     (Gnt0),
        .Gnt1     (Gnt1),
        .RValid0  (RValid0),
        .RValid1  (RValid1),
        .RData    (RData),
        .MemAddr  (MemAddr),
        .MemRE    (MemRE),
        .MemWE    (MemWE),
        .MemWData (MemWData),
        .MemRData (MemRData)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [7:0] rom(input logic [4:0] a);
        return {3'b011, a};
    endfunction

    // Memory model: data for address sampled with MemRE appears 2 cycles later
    logic [7:0] mp0, mp1;
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            mp0 <= 8'h00;
            mp1 <= 8'h00;
        end else begin
            mp0 <= MemRE ? rom(MemAddr) : 8'h00;
            mp1 <= mp0;
        end
    end
    assign MemRData = mp1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {5'd0, Gnt0, Gnt1, RValid0, RValid1, MemRE, MemWE,
                   MemAddr, MemWData, RData}, 32'd0);
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic expect_read(input bit tag, input logic [4:0] a);
        exp_q.push_back('{tag, rom(a), cyc + 2});
    endtask

    task automatic clr_cmds();
        RdEn0 = 1'b0; RdEn1 = 1'b0; WrEn0 = 1'b0; WrEn1 = 1'b0;
        Addr0 = 5'd0; Addr1 = 5'd0; WData0 = 8'h00; WData1 = 8'h00;
    endtask

    // Scoreboard monitor: every read return must match the oldest expectation
    always @(negedge Clock) begin
        if (RValid0 || RValid1) begin
            exp_t e;
            if (RValid0 && RValid1) begin
                chk("rv_both", 32'd1, 32'd0);
            end
            if (exp_q.size() == 0) begin
                chk("rv_unexpected", {31'd0, RValid1}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rv_tag",   {31'd0, RValid1}, {31'd0, e.tag});
                chk("rv_data",  {24'd0, RData},   {24'd0, e.data});
                chk("rv_cycle", cyc,              e.cyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; Req0 = 1'b0; Req1 = 1'b0;
        clr_cmds();

        // Reset state
        #3;
        chk_all_zero("rst_hold");
        step(); step();
        Reset = 1'b0;
        settle();
        chk_all_zero("post_rst");

        // Single requester, read of address 5
        step();
        Req0 = 1'b1;
        settle();
        chk("idle_gnt0", {31'd0, Gnt0}, 32'd0);
        step();
        RdEn0 = 1'b1; Addr0 = 5'd5;
        settle();
        chk("own0_gnt0", {31'd0, Gnt0}, 32'd1);
        chk("own0_gnt1", {31'd0, Gnt1}, 32'd0);
        chk("rd5_re",    {31'd0, MemRE}, 32'd1);
        chk("rd5_addr",  {27'd0, MemAddr}, 32'd5);
        chk("rd5_we",    {31'd0, MemWE}, 32'd0);
        expect_read(1'b0, 5'd5);
        step();
        clr_cmds(); Req0 = 1'b0;
        settle();
        chk("rd5_re_off", {31'd0, MemRE}, 32'd0);
        repeat (5) step();

        // Tie after reset goes to requester 0; non-owner commands ignored
        Reset = 1'b1;
        step(); step();
        Reset = 1'b0;
        Req0 = 1'b1; Req1 = 1'b1;
        settle();
        chk("tie_idle", {30'd0, Gnt0, Gnt1}, 32'd0);
        step();
        WrEn1 = 1'b1; WData1 = 8'h77; Addr1 = 5'd9;
        settle();
        chk("tie_gnt", {30'd0, Gnt0, Gnt1}, 32'd2);
        chk("nonowner_we", {31'd0, MemWE}, 32'd0);
        chk("nonowner_addr", {27'd0, MemAddr}, 32'd0);
        step();
        WrEn0 = 1'b1; WData0 = 8'h3C; Addr0 = 5'd7;
        settle();
        chk("own_we", {31'd0, MemWE}, 32'd1);
        chk("own_wdata", {24'd0, MemWData}, 32'h3C);
        chk("own_waddr", {27'd0, MemAddr}, 32'd7);
        // Read and write together: write only, no return
        step();
        RdEn0 = 1'b1; WrEn0 = 1'b1; Addr0 = 5'd3; WData0 = 8'hA5;
        WrEn1 = 1'b0; RdEn1 = 1'b1;
        settle();
        chk("rw_we", {31'd0, MemWE}, 32'd1);
        chk("rw_re", {31'd0, MemRE}, 32'd0);
        chk("rw_addr", {27'd0, MemAddr}, 32'd3);
        chk("rw_wdata", {24'd0, MemWData}, 32'hA5);
        step();
        clr_cmds(); Req0 = 1'b0;
        settle();
        chk("rel_last_own", {31'd0, Gnt0}, 32'd1);
        step();
        WrEn1 = 1'b1; Addr1 = 5'd9;
        settle();
        chk("drain1_gnt", {30'd0, Gnt0, Gnt1}, 32'd0);
        chk("drain1_we", {31'd0, MemWE}, 32'd0);
        step();
        settle();
        chk("drain2_gnt", {30'd0, Gnt0, Gnt1}, 32'd0);
        step();
        settle();
        chk("idle_gnt", {30'd0, Gnt0, Gnt1}, 32'd0);
        chk("idle_addr", {27'd0, MemAddr}, 32'd0);
        step();
        WrEn1 = 1'b0; RdEn1 = 1'b1;
        settle();
        chk("own1_gnt", {30'd0, Gnt0, Gnt1}, 32'd1);
        chk("own1_addr", {27'd0, MemAddr}, 32'd9);
        chk("own1_re", {31'd0, MemRE}, 32'd1);
        expect_read(1'b1, 5'd9);
        step();
        clr_cmds(); Req1 = 1'b0;
        repeat (4) step();

        // Hold counter saturates while nobody waits; release on next request
        Req0 = 1'b1;
        step();
        for (int k = 0; k < 40; k++) begin
            RdEn0 = 1'b1; Addr0 = 5'(k);
            settle();
            chk("sat_gnt0", {31'd0, Gnt0}, 32'd1);
            chk("sat_re", {31'd0, MemRE}, 32'd1);
            expect_read(1'b0, 5'(k));
            step();
        end
        Req1 = 1'b1; Addr0 = 5'd8;
        settle();
        chk("sat_still_own", {31'd0, Gnt0}, 32'd1);
        expect_read(1'b0, 5'd8);
        step();
        settle();
        chk("sat_release", {31'd0, Gnt0}, 32'd0);
        chk("sat_release_re", {31'd0, MemRE}, 32'd0);
        clr_cmds(); Req0 = 1'b0; Req1 = 1'b0;
        repeat (5) step();

        // Forced release after 32 owned cycles while requester 1 waits
        Req0 = 1'b1;
        step();
        Req1 = 1'b1;
        for (int k = 0; k < 40; k++) begin
            RdEn0 = 1'b1; Addr0 = 5'(k);
            settle();
            if (k < 32) begin
                chk("burst_gnt0", {31'd0, Gnt0}, 32'd1);
                chk("burst_re", {31'd0, MemRE}, 32'd1);
                expect_read(1'b0, 5'(k));
            end else begin
                chk("burst_gnt0_off", {31'd0, Gnt0}, 32'd0);
                chk("burst_re_off", {31'd0, MemRE}, 32'd0);
            end
            chk("burst_gnt1", {31'd0, Gnt1}, (k >= 35) ? 32'd1 : 32'd0);
            step();
        end
        clr_cmds(); Req0 = 1'b0; Req1 = 1'b0;
        repeat (5) step();

        // Reset one cycle after a read: nothing may return
        Req0 = 1'b1;
        step();
        RdEn0 = 1'b1; Addr0 = 5'd4;
        settle();
        chk("prerst_re", {31'd0, MemRE}, 32'd1);
        step();
        Reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        clr_cmds(); Req0 = 1'b0;
        step(); step();
        Reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("no_rv_after_rst", {30'd0, RValid0, RValid1}, 32'd0);
            step();
        end

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_W, default 5, memory address width (32 words).
REQ-003 SHALL have parameter READ_LAT, default 2, cycles from accepted read to MemRData valid.
REQ-004 SHALL have parameter MAX_HOLD, default 32, maximum consecutive owned cycles while the other requester waits.
REQ-005 SHALL have port Clock  in  1  sole clock, rising edge.
REQ-006 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have ports Req0/Req1  in  1  requester i wants ownership of the memory port.
REQ-008 SHALL have ports Addr0/Addr1  in  ADDR_W  requester i address.
REQ-009 SHALL have ports RdEn0/RdEn1, WrEn0/WrEn1  in  1  requester i read/write command.
REQ-010 SHALL have ports WData0/WData1  in  DATA_W  requester i write data.
REQ-011 SHALL have ports Gnt0/Gnt1  out  1  requester i currently owns the port (registered).
REQ-012 SHALL have ports RValid0/RValid1  out  1  read data for requester i is valid on RData.
REQ-013 SHALL have port RData  out  DATA_W  MemRData passed through.
REQ-014 SHALL have ports MemAddr (ADDR_W), MemRE, MemWE, MemWData (DATA_W)  out  memory command.
REQ-015 SHALL have port MemRData  in  DATA_W  memory read data.

Function
REQ-016 SHALL implement states IDLE, OWN0, OWN1, DRAIN; Gnt0=1 only in OWN0, Gnt1=1 only in OWN1.
REQ-017 IDLE: only Req0 -> OWN0; only Req1 -> OWN1; both -> the requester not equal to Last; neither -> stay; Gnt rises the cycle after Req is sampled.
REQ-018 SHALL update Last to the granted index on every entry to OWNx.
REQ-019 OWNx: Reqx=0 -> DRAIN; HoldCnt==MAX_HOLD-1 with other Req=1 -> DRAIN (forced release); otherwise stay.
REQ-020 HoldCnt SHALL clear on OWNx entry, increment each OWNx cycle, and saturate at MAX_HOLD-1 while the other Req is low.
REQ-021 DRAIN SHALL last exactly READ_LAT cycles (down-counter), then go to IDLE; no memory command is issued in DRAIN or IDLE.
REQ-022 In OWNx, MemAddr/MemWData SHALL equal Addrx/WDatax combinationally; MemWE=WrEnx; MemRE=RdEnx&~WrEnx.
REQ-023 Owner asserting RdEn and WrEn in the same cycle SHALL perform the write only; no RValid generated.
REQ-024 Outside OWNx, MemRE=MemWE=0, MemAddr=0 and MemWData=0; commands from the non-owner SHALL be ignored.
REQ-025 Each issued read SHALL produce RValidx=1 for exactly one cycle, READ_LAT cycles later, tagged with the issuing owner, including reads issued in the last OWN cycle.
REQ-026 Back-to-back reads SHALL be accepted every cycle; throughput one access per cycle while owned.
REQ-027 Forced release SHALL drop Gnt the next cycle even if the owner is mid-burst; the owner must re-request.

Reset
REQ-028 On Reset=1 SHALL asynchronously enter IDLE with Last=1 (requester 0 wins the first tie), HoldCnt=0, drain counter=0, read-tag pipeline empty.
REQ-029 All outputs SHALL be 0 during and immediately after reset; reads in flight at reset SHALL produce no RValid.

Structure
REQ-030 State encoding, default parameter values and the requester-index type SHALL live in shared package mem_arb_pkg.
REQ-031 The read-return tag pipeline (READ_LAT-deep valid+owner shift register) SHALL be sub-module mem_arb_rtag_pipe.

Verification
REQ-032 Reset, Req0=1 only -> Gnt0=1 on the cycle after Req0 is sampled; read Addr0=5 -> MemRE=1, MemAddr=5; RValid0=1 two cycles later.
REQ-033 Req0=Req1=1 from IDLE after reset -> OWN0; Req0 drops -> Gnt0=0, 2 DRAIN cycles, then Gnt1=1.
REQ-034 Owner 0 streams reads for 40 cycles while Req1=1 -> Gnt0 falls after 32 owned cycles; all 32 reads return RValid0, none on RValid1.
REQ-035 Owner issues RdEn=WrEn=1, Addr=3, WData=8'hA5 -> MemWE=1, MemRE=0, no RValid.
REQ-036 Reset asserted one cycle after a read is issued -> outputs 0 immediately; no RValid appears after Reset deasserts.
REQ-037 Non-owner drives WrEn1=1 while Gnt0=1 -> MemWE reflects only WrEn0.
